// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: bundle for the data-SRAM port.
//   master modport: requester (execute stage / testbench). It drives en/we/addr/wdata
//                   and observes rdata/rdata_valid/acc_err/rd_cnt/wr_cnt.
//   slave modport : data_sram_resp responder.
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        rdata_valid;
    logic        acc_err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, rdata_valid, acc_err, rd_cnt, wr_cnt
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, rdata_valid, acc_err, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp: word-organised data SRAM that responds to the EX-stage request port.
//   Byte write enables, READ_LATENCY-deep read pipeline (1..4), sticky out-of-range
//   flag, and saturating read/write access counters.
// Ports:
//   clk - clock
//   rst - synchronous, active-high reset
//   bus - data_sram_resp_if.slave. Inputs: en/we/addr/wdata. Outputs: rdata,
//         rdata_valid, acc_err, rd_cnt, wr_cnt.
// Optional feature: define DSRAM_WRITE_FIRST_EN to make a write access return the merged
//   new word. Without it, a write access returns the old word (read-first).
module data_sram_resp #(
    parameter int          ADDR_WIDTH   = 14,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    data_sram_resp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  req, wr_req, rd_req;
    logic [31:0]           old_word, new_word, resp_d;
    logic                  unused_byte_sel;

    // Requests seen while rst is high are dropped entirely.
    assign offset          = bus.data_sram_addr - BASE_ADDR;
    assign in_range        = (offset[31:ADDR_WIDTH+2] == '0);
    assign idx             = offset[ADDR_WIDTH+1:2];
    assign unused_byte_sel = ^offset[1:0];
    assign req             = bus.data_sram_en && !rst;
    assign wr_req          = req && (bus.data_sram_we != 4'h0);
    assign rd_req          = req && (bus.data_sram_we == 4'h0);
    assign old_word        = mem[idx];

    always_comb begin
        new_word = old_word;
        for (int b = 0; b < 4; b++)
            if (bus.data_sram_we[b]) new_word[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
    end

    // Word that enters the read pipeline. An out-of-range access returns zero.
    always_comb begin
        resp_d = 32'h0;
        if (in_range) begin
`ifdef DSRAM_WRITE_FIRST_EN
            resp_d = wr_req ? new_word : old_word;
`else
            resp_d = old_word;
`endif
        end
    end

    // The memory array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_req && in_range)
            for (int b = 0; b < 4; b++)
                if (bus.data_sram_we[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
    end

    // Stage 0 is loaded at the request edge. The last stage is the rdata register itself.
    // It loads only when a valid read arrives, so it holds its value between reads.
    // Intermediate stages shift unconditionally.
    logic [READ_LATENCY-1:0] vld_pipe_q;
    logic [31:0]             dat_pipe_q [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) dat_pipe_q[k] <= 32'h0;
        end else begin
            vld_pipe_q[0] <= req;
            if (READ_LATENCY > 1 || req) dat_pipe_q[0] <= resp_d;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                if (k < READ_LATENCY - 1 || vld_pipe_q[k-1]) dat_pipe_q[k] <= dat_pipe_q[k-1];
            end
        end
    end

    assign bus.data_sram_rdata = dat_pipe_q[READ_LATENCY-1];
    assign bus.rdata_valid     = vld_pipe_q[READ_LATENCY-1];

    // Sticky error flag and saturating counters.
    logic        acc_err_q, acc_err_d;
    logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    always_comb begin
        acc_err_d = acc_err_q | (req && !in_range);
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        if (rd_req && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        if (wr_req && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_err_q <= 1'b0;
            rd_cnt_q  <= 16'h0;
            wr_cnt_q  <= 16'h0;
        end else begin
            acc_err_q <= acc_err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign bus.acc_err = acc_err_q;
    assign bus.rd_cnt  = rd_cnt_q;
    assign bus.wr_cnt  = wr_cnt_q;
endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;
    localparam int          LAT  = 3;
    localparam int          AW   = 14;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_sram_resp_if bus();

    data_sram_resp #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int npulse = 0;
    longint edge_n = 0;

    // Reference model: memory keyed by word index. Completions are keyed by the edge
    // after which they become visible.
    logic [31:0] mdl_mem [longint];
    logic [31:0] pend_d  [longint];
    logic [31:0] m_rdata = 32'h0;
    bit          m_acc   = 1'b0;
    int          m_rd    = 0;
    int          m_wr    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive the request, advance the model by one edge, then check every output.
    task automatic tick(input bit r, input bit en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wd);
        longint      off, w;
        bit          inr, exp_v;
        logic [31:0] old, nw, ret;
        rst                 = r;
        bus.data_sram_en    = en;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wd;
        @(posedge clk);
        edge_n++;
        if (r) begin
            pend_d.delete();
            m_rdata = 32'h0; m_acc = 1'b0; m_rd = 0; m_wr = 0;
        end else if (en) begin
            off = longint'(addr - BASE);
            inr = off < (longint'(1) << (AW + 2));
            w   = off / 4;
            old = (inr && mdl_mem.exists(w)) ? mdl_mem[w] : 32'h0;
            nw  = old;
            for (int b = 0; b < 4; b++) if (we[b]) nw[8*b +: 8] = wd[8*b +: 8];
            ret = inr ? old : 32'h0;
`ifdef DSRAM_WRITE_FIRST_EN
            if (inr && we != 4'h0) ret = nw;
`endif
            if (we != 4'h0) begin
                if (m_wr < 65535) m_wr++;
                if (inr) mdl_mem[w] = nw;
            end else if (m_rd < 65535) m_rd++;
            if (!inr) m_acc = 1'b1;
            pend_d[edge_n + LAT - 1] = ret;
        end
        exp_v = pend_d.exists(edge_n);
        if (exp_v) begin
            m_rdata = pend_d[edge_n];
            pend_d.delete(edge_n);
        end
        #1;
        if (bus.rdata_valid === 1'b1) npulse++;
        chk("rdata_valid", 32'(bus.rdata_valid), 32'(exp_v));
        chk("rdata", bus.data_sram_rdata, m_rdata);
        chk("acc_err", 32'(bus.acc_err), 32'(m_acc));
        chk("rd_cnt", 32'(bus.rd_cnt), 32'(m_rd));
        chk("wr_cnt", 32'(bus.wr_cnt), 32'(m_wr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  we;
        bit          en, r;

        // Reset, then check the reset state directly.
        tick(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(1'b1, 1'b1, 4'hF, 32'h40, 32'h1234_5678);
        chk("reset_rdata", bus.data_sram_rdata, 32'h0);
        chk("reset_valid", 32'(bus.rdata_valid), 32'h0);
        chk("reset_cnt", 32'({bus.rd_cnt, bus.wr_cnt}), 32'h0);

        // Preload the random-access window (words 0..63) so every later read is defined.
        for (int i = 0; i < 64; i++) tick(1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom);
        tick(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

        // Full write then read.
        tick(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        tick(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        idle(LAT - 1);
        chk("t1_data", bus.data_sram_rdata, 32'hDEAD_BEEF);
        chk("t1_valid", 32'(bus.rdata_valid), 32'h1);
        chk("t1_wr_cnt", 32'(bus.wr_cnt), 32'h1);
        chk("t1_rd_cnt", 32'(bus.rd_cnt), 32'h1);

        // Byte enables.
        tick(1'b0, 1'b1, 4'hF, 32'h20, 32'h1122_3344);
        tick(1'b0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        tick(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);
        idle(LAT - 1);
        chk("t2_bytes", bus.data_sram_rdata, 32'h11BB_33DD);

        // Same-cycle read/write of one word.
        tick(1'b0, 1'b1, 4'hF, 32'h30, 32'h5);
        tick(1'b0, 1'b1, 4'hF, 32'h30, 32'h9);
        idle(LAT - 1);
`ifdef DSRAM_WRITE_FIRST_EN
        chk("t3_wr_ret", bus.data_sram_rdata, 32'h9);
`else
        chk("t3_wr_ret", bus.data_sram_rdata, 32'h5);
`endif
        tick(1'b0, 1'b1, 4'h0, 32'h30, 32'h0);
        idle(LAT - 1);
        chk("t3_after", bus.data_sram_rdata, 32'h9);

        // Out of range: returns zero, sets the sticky flag, and does not alias word 0.
        tick(1'b0, 1'b1, 4'h0, 32'h0001_0000, 32'h0);
        idle(LAT - 1);
        chk("t4_data", bus.data_sram_rdata, 32'h0);
        chk("t4_valid", 32'(bus.rdata_valid), 32'h1);
        chk("t4_err", 32'(bus.acc_err), 32'h1);
        tick(1'b0, 1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D);
        tick(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        idle(LAT + 2);
        chk("t4_sticky", 32'(bus.acc_err), 32'h1);
        chk("t4_noalias", bus.data_sram_rdata, mdl_mem[0]);

        // Four back-to-back reads produce four pulses.
        npulse = 0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'h0, 32'(32'h10 + i * 4), 32'h0);
        idle(LAT + 2);
        chk("t5_pulses", 32'(npulse), 32'd4);

        // Reset after the second read discards everything in flight.
        tick(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        tick(1'b0, 1'b1, 4'h0, 32'h14, 32'h0);
        npulse = 0;
        tick(1'b1, 1'b1, 4'h0, 32'h18, 32'h0);
        tick(1'b1, 1'b1, 4'hF, 32'h1C, 32'hFFFF_FFFF);
        chk("t5_rst_cnt", 32'({bus.rd_cnt, bus.wr_cnt}), 32'h0);
        idle(LAT + 2);
        chk("t5_rst_pulses", 32'(npulse), 32'd0);

        // Random traffic within the preloaded window, plus out-of-range accesses and resets.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom % 50) == 0;
            en = ($urandom % 4) != 0;
            we = ($urandom % 2) ? 4'($urandom) : 4'h0;
            a  = (($urandom % 8) == 0) ? (32'h0001_0000 + ($urandom % 32'h1000)) : ($urandom % 32'h100);
            d  = $urandom;
            tick(r, en, we, a, d);
        end
        idle(LAT);

        // Read counter saturation.
        tick(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 65540; i++) tick(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        chk("sat_rd", 32'(bus.rd_cnt), 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'h0, 32'h4, 32'h0);
        idle(LAT);
        chk("sat_hold", 32'(bus.rd_cnt), 32'h0000_FFFF);
        chk("sat_wr", 32'(bus.wr_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
